// File: rtl/abro_stim_checker_pkg.sv
// abro_stim_checker_pkg: shared FSM encodings, LFSR taps and helpers for the ABRO stimulus checker
package abro_stim_checker_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_DEF  = 16'hACE1;
    localparam int          LEN_W_DEF = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] fix_seed(input logic [15:0] s);
        return s == 16'h0000 ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/abro_lfsr16.sv
// abro_lfsr16: 16-bit Fibonacci LFSR with seed load and zero-seed lockup protection
module abro_lfsr16
    import abro_stim_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // load has priority over step; an all-zero seed would lock the register, so it is remapped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 16'h0001;
        else if (load) q <= fix_seed(seed);
        else if (step) q <= lfsr_next(q);
    end

endmodule

// File: rtl/abro_stim_checker.sv
// abro_stim_checker: drives pseudo-random A/B/R into an ABRO core and checks O against a golden model
module abro_stim_checker
    import abro_stim_checker_pkg::*;
#(
    parameter logic [15:0] SEED  = SEED_DEF,
    parameter int          LEN_W = LEN_W_DEF
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    output logic             A,
    output logic             B,
    output logic             R,
    input  logic             O,
    output logic             busy,
    output logic             done,
    output logic [15:0]      err_cnt,
    output logic [LEN_W-1:0] cyc_cnt,
    output logic [LEN_W-1:0] first_err_cyc
);

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [15:0]      q;
    logic [15:0]      v;
    logic             seen_a, seen_b, fired;
    logic             go, chk, last, step, na, nb, exp_o, miss;

    abro_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (go),
        .step (step),
        .seed (SEED),
        .q    (q)
    );

    // sequencing decode and golden-model expectation for the cycle currently being driven
    always_comb begin
        go    = start && state == S_IDLE;
        chk   = state == S_SYNC || state == S_RUN;
        last  = state == S_SYNC ? len_q == '0 : cyc_cnt == len_q;
        step  = chk && !last;
        v     = lfsr_next(q);
        na    = seen_a | A;
        nb    = seen_b | B;
        exp_o = !R && na && nb && !fired;
        miss  = chk && (O != exp_o);
    end

    // IDLE -> SYNC -> RUN x run_len -> FIN -> IDLE; run_len is latched so later changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            len_q <= '0;
        end else begin
            state <= go ? S_SYNC : chk ? (last ? S_FIN : S_RUN) : state == S_FIN ? S_IDLE : state;
            len_q <= go ? run_len : len_q;
        end
    end

    // stimulus registers: reset pulse in SYNC, LFSR-derived values in RUN, quiet otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {A, B, R} <= 3'b000;
        else if (go) {A, B, R} <= 3'b001;
        else if (step) {A, B, R} <= {v[4] & v[5], v[6] & v[7], v[3:0] == 4'h0};
        else if (chk) {A, B, R} <= 3'b000;
    end

    // golden ABRO state: R preempts everything, O fires once when both A and B have been seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {seen_a, seen_b, fired} <= 3'b000;
        else if (chk) {seen_a, seen_b, fired} <= R ? 3'b000 : {na, nb, fired | exp_o};
    end

    // result counters: cleared on start, updated after every checked cycle, held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt       <= '0;
            cyc_cnt       <= '0;
            first_err_cyc <= '1;
        end else if (go) begin
            err_cnt       <= '0;
            cyc_cnt       <= '0;
            first_err_cyc <= '1;
        end else if (chk) begin
            cyc_cnt       <= cyc_cnt + 1'b1;
            err_cnt       <= miss && err_cnt != 16'hFFFF ? err_cnt + 16'd1 : err_cnt;
            first_err_cyc <= miss && err_cnt == '0 ? cyc_cnt : first_err_cyc;
        end
    end

    assign busy = state != S_IDLE;
    assign done = state == S_FIN;

endmodule

// File: tb/tb_abro_stim_checker.sv
// tb_abro_stim_checker: plays the ABRO core (good, stuck or random O) and checks the checker's verdicts
module tb_abro_stim_checker;

    logic        clk = 1'b0;
    logic        rst, start, O, A, B, R, busy, done;
    logic [15:0] run_len, err_cnt, cyc_cnt, first_err_cyc;

    int n_vec = 0;
    int n_err = 0;

    bit sa [0:1100];
    bit sb [0:1100];
    bit sr [0:1100];
    bit ex [0:1100];
    bit op [0:1100];

    int busy_cnt, done_cnt, r_cnt, stim_bad, exp_err, exp_first;

    abro_stim_checker dut (
        .rst           (rst),
        .clk           (clk),
        .start         (start),
        .run_len       (run_len),
        .A             (A),
        .B             (B),
        .R             (R),
        .O             (O),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .cyc_cnt       (cyc_cnt),
        .first_err_cyc (first_err_cyc)
    );

    always #5 clk = ~clk;

    // Expected stimulus and ABRO output per cycle: O fires on the cycle at which the later of
    // the first A and first B since the most recent R occurs. mode: 0 good, 1 O=0, 2 O=1, 3 random.
    function automatic void build(input int len, input int mode);
        logic [15:0] v = 16'hACE1;
        int fa = -1;
        int fb = -1;
        exp_err = 0;
        exp_first = 16'hFFFF;
        for (int k = 0; k <= len; k++) begin
            if (k == 0) begin
                sr[k] = 1; sa[k] = 0; sb[k] = 0;
            end else begin
                v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
                sr[k] = (v[3:0] == 4'd0); sa[k] = v[4] && v[5]; sb[k] = v[6] && v[7];
            end
            if (sr[k]) begin
                fa = -1; fb = -1; ex[k] = 0;
            end else begin
                if (sa[k] && fa < 0) fa = k;
                if (sb[k] && fb < 0) fb = k;
                ex[k] = fa >= 0 && fb >= 0 && k == (fa > fb ? fa : fb);
            end
            op[k] = mode == 0 ? ex[k] : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : 1'($urandom_range(1, 0));
            if (op[k] != ex[k]) begin
                if (exp_err == 0) exp_first = k;
                exp_err++;
            end
        end
    endfunction

    // Start a run, answer with op[] each cycle, tally observations; abort_at asserts rst there.
    task automatic drive_run(input int len, input int abort_at, input int restart_at);
        busy_cnt = 0; done_cnt = 0; r_cnt = 0; stim_bad = 0;
        @(negedge clk);
        start = 1; run_len = len[15:0];
        @(negedge clk);
        start = 0; run_len = 16'($urandom);
        for (int k = 0; k <= len; k++) begin
            if (k == abort_at) begin
                rst = 1;
                #1;
                return;
            end
            O = op[k];
            if ({A, B, R} !== {sa[k], sb[k], sr[k]}) stim_bad++;
            busy_cnt += int'(busy); done_cnt += int'(done); r_cnt += int'(R);
            start = (k == restart_at);
            if (k == restart_at) run_len = 16'd3;
            @(negedge clk);
        end
        start = 0; O = 0;
        for (int k = 0; k < 4; k++) begin
            busy_cnt += int'(busy); done_cnt += int'(done); r_cnt += int'(R);
            if (A | B | R) stim_bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; O = 0; run_len = 0;
        repeat (2) @(negedge clk);
        n_vec++; if ({A, B, R, busy, done} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 00000", {A, B, R, busy, done}); end
        n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        n_vec++; if (cyc_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cyc: got %0d want 0", cyc_cnt); end
        n_vec++; if (first_err_cyc !== 16'hFFFF) begin n_err++; $display("FAIL reset_first: got %h want ffff", first_err_cyc); end
        rst = 0;
    endtask

    task automatic test_good_core();
        build(1000, 0);
        drive_run(1000, -1, -1);
        n_vec++; if (stim_bad != 0) begin n_err++; $display("FAIL good_stim: got %0d bad cycles want 0", stim_bad); end
        n_vec++; if (busy_cnt != 1002) begin n_err++; $display("FAIL good_busy: got %0d want 1002", busy_cnt); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL good_done: got %0d want 1", done_cnt); end
        n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL good_err: got %0d want 0", err_cnt); end
        n_vec++; if (cyc_cnt !== 16'd1001) begin n_err++; $display("FAIL good_cyc: got %0d want 1001", cyc_cnt); end
        n_vec++; if (first_err_cyc !== 16'hFFFF) begin n_err++; $display("FAIL good_first: got %h want ffff", first_err_cyc); end
    endtask

    task automatic test_o_stuck();
        build(300, 1);
        drive_run(300, -1, -1);
        n_vec++; if (err_cnt !== exp_err[15:0]) begin n_err++; $display("FAIL stuck0_err: got %0d want %0d", err_cnt, exp_err); end
        n_vec++; if (first_err_cyc !== exp_first[15:0]) begin n_err++; $display("FAIL stuck0_first: got %0d want %0d", first_err_cyc, exp_first); end
        build(10, 2);
        drive_run(10, -1, -1);
        n_vec++; if (err_cnt !== exp_err[15:0]) begin n_err++; $display("FAIL stuck1_err: got %0d want %0d", err_cnt, exp_err); end
        n_vec++; if (first_err_cyc !== exp_first[15:0]) begin n_err++; $display("FAIL stuck1_first: got %0d want %0d", first_err_cyc, exp_first); end
        n_vec++; if (cyc_cnt !== 16'd11) begin n_err++; $display("FAIL stuck1_cyc: got %0d want 11", cyc_cnt); end
    endtask

    task automatic test_zero_len();
        build(0, 0);
        drive_run(0, -1, -1);
        n_vec++; if (busy_cnt != 2) begin n_err++; $display("FAIL zero_busy: got %0d want 2", busy_cnt); end
        n_vec++; if (r_cnt != 1) begin n_err++; $display("FAIL zero_r: got %0d want 1", r_cnt); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
        n_vec++; if (cyc_cnt !== 16'd1) begin n_err++; $display("FAIL zero_cyc: got %0d want 1", cyc_cnt); end
        n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL zero_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int len = $urandom_range(300, 1);
            build(len, 3);
            drive_run(len, -1, -1);
            n_vec++; if (stim_bad != 0) begin n_err++; $display("FAIL rand_stim[%0d]: got %0d bad cycles want 0", i, stim_bad); end
            n_vec++; if (err_cnt !== exp_err[15:0]) begin n_err++; $display("FAIL rand_err[%0d]: got %0d want %0d", i, err_cnt, exp_err); end
            n_vec++; if (first_err_cyc !== exp_first[15:0]) begin n_err++; $display("FAIL rand_first[%0d]: got %0d want %0d", i, first_err_cyc, exp_first); end
            n_vec++; if (cyc_cnt !== 16'(len + 1)) begin n_err++; $display("FAIL rand_cyc[%0d]: got %0d want %0d", i, cyc_cnt, len + 1); end
        end
    endtask

    task automatic test_abort();
        int dn = 0;
        build(200, 2);
        drive_run(200, 50, -1);
        @(posedge clk); #1;
        n_vec++; if ({A, B, R, busy, done} !== 5'b0) begin n_err++; $display("FAIL abort_ctrl: got %b want 00000", {A, B, R, busy, done}); end
        n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL abort_err: got %0d want 0", err_cnt); end
        n_vec++; if (cyc_cnt !== 16'd0) begin n_err++; $display("FAIL abort_cyc: got %0d want 0", cyc_cnt); end
        n_vec++; if (first_err_cyc !== 16'hFFFF) begin n_err++; $display("FAIL abort_first: got %h want ffff", first_err_cyc); end
        @(negedge clk); rst = 0; O = 0;
        repeat (6) begin @(negedge clk); dn += int'(done) + int'(busy); end
        n_vec++; if (dn != 0) begin n_err++; $display("FAIL abort_done: got %0d done/busy cycles want 0", dn); end
    endtask

    task automatic test_start_during_run();
        build(100, 3);
        drive_run(100, -1, 20);
        n_vec++; if (busy_cnt != 102) begin n_err++; $display("FAIL restart_busy: got %0d want 102", busy_cnt); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
        n_vec++; if (stim_bad != 0) begin n_err++; $display("FAIL restart_stim: got %0d bad cycles want 0", stim_bad); end
        n_vec++; if (err_cnt !== exp_err[15:0]) begin n_err++; $display("FAIL restart_err: got %0d want %0d", err_cnt, exp_err); end
        n_vec++; if (cyc_cnt !== 16'd101) begin n_err++; $display("FAIL restart_cyc: got %0d want 101", cyc_cnt); end
    endtask

    task automatic test_back_to_back();
        build(40, 2);
        drive_run(40, -1, -1);
        build(25, 0);
        drive_run(25, -1, -1);
        n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_err: got %0d want 0", err_cnt); end
        n_vec++; if (first_err_cyc !== 16'hFFFF) begin n_err++; $display("FAIL b2b_first: got %h want ffff", first_err_cyc); end
        n_vec++; if (cyc_cnt !== 16'd26) begin n_err++; $display("FAIL b2b_cyc: got %0d want 26", cyc_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_core();
        test_o_stuck();
        test_zero_len();
        test_random();
        test_abort();
        test_start_during_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
